pp_od_drv_seq: RTL

Multi-channel pad driver sequencer for the I3C PHY. It converts a per-channel requested line level and drive mode (push-pull or open-drain) into registered `pull_up_en_o`/`pull_down_en_o` controls for the pad buffers. Any direct pull-up to pull-down change (or the reverse) passes through a break-before-make dead time, so both enables are never asserted together. The block sits between the bus controller's SCL/SDA drive logic and the pad buffer instances.

---
 rtl/pp_od_drv_seq_if.sv | 24 ++
 rtl/pp_od_drv_seq.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pp_od_drv_seq_if.sv
// Pad drive request/status bundle for pp_od_drv_seq.
// master = bus controller side, slave = sequencer side.
interface pp_od_drv_seq_if #(
   parameter int NUM_CH = 2
);
   logic [NUM_CH-1:0] mode_pp_i;
   logic [NUM_CH-1:0] data_i;
   logic [NUM_CH-1:0] bus_i;
   logic [NUM_CH-1:0] conflict_clr_i;
   logic [NUM_CH-1:0] pull_up_en_o;
   logic [NUM_CH-1:0] pull_down_en_o;
   logic [NUM_CH-1:0] busy_o;
   logic [NUM_CH-1:0] conflict_o;

   modport master (
      output mode_pp_i, data_i, bus_i, conflict_clr_i,
      input  pull_up_en_o, pull_down_en_o, busy_o, conflict_o
   );

   modport slave (
      input  mode_pp_i, data_i, bus_i, conflict_clr_i,
      output pull_up_en_o, pull_down_en_o, busy_o, conflict_o
   );
endinterface

// File: rtl/pp_od_drv_seq.sv
// Per-channel push-pull/open-drain pad sequencer with break-before-make.
// PP_OD_DRV_CONFLICT_DET_EN enables the sticky drive-conflict detector.
module pp_od_drv_seq #(
   parameter int NUM_CH      = 2,
   parameter int DEAD_CYCLES = 2
) (
   input logic clk_i,
   input logic rst_i,
   pp_od_drv_seq_if.slave io
);
   localparam int CW = $clog2(DEAD_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DEAD_CYCLES - 1);

   localparam logic [1:0] ST_OFF  = 2'd0;
   localparam logic [1:0] ST_PD   = 2'd1;
   localparam logic [1:0] ST_PU   = 2'd2;
   localparam logic [1:0] ST_DEAD = 2'd3;

   if (DEAD_CYCLES < 1) begin : g_bad_dead
      $error("DEAD_CYCLES must be >= 1");
   end
   if (NUM_CH < 1) begin : g_bad_ch
      $error("NUM_CH must be >= 1");
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [1:0]    st_q;
      logic [1:0]    st_nx;
      logic [1:0]    tgt;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_nx;

      always_comb begin
         tgt = ST_OFF;
         if (!io.data_i[c]) begin
            tgt = ST_PD;
         end else if (io.mode_pp_i[c]) begin
            tgt = ST_PU;
         end
      end

      // A PD<->PU swap always serves the full dead time; only a
      // release to OFF may leave DEAD early.
      always_comb begin
         st_nx  = st_q;
         cnt_nx = cnt_q;
         case (st_q)
            ST_OFF: st_nx = tgt;
            ST_PD: begin
               if (tgt == ST_PU) begin
                  st_nx  = ST_DEAD;
                  cnt_nx = CNT_LOAD;
               end else begin
                  st_nx = tgt;
               end
            end
            ST_PU: begin
               if (tgt == ST_PD) begin
                  st_nx  = ST_DEAD;
                  cnt_nx = CNT_LOAD;
               end else begin
                  st_nx = tgt;
               end
            end
            default: begin
               if (tgt == ST_OFF) begin
                  st_nx  = ST_OFF;
                  cnt_nx = '0;
               end else if (cnt_q == '0) begin
                  st_nx = tgt;
               end else begin
                  cnt_nx = cnt_q - CW'(1);
               end
            end
         endcase
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            st_q  <= ST_OFF;
            cnt_q <= '0;
         end else begin
            st_q  <= st_nx;
            cnt_q <= cnt_nx;
         end
      end

      assign io.pull_up_en_o[c]   = (st_q == ST_PU);
      assign io.pull_down_en_o[c] = (st_q == ST_PD);
      assign io.busy_o[c]         = (st_q == ST_DEAD);

`ifdef PP_OD_DRV_CONFLICT_DET_EN
      logic low_q;
      logic cf_q;
      logic cf_set;

      assign cf_set = (st_q == ST_PU) && !io.bus_i[c] && low_q;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            low_q <= 1'b0;
            cf_q  <= 1'b0;
         end else begin
            low_q <= (st_q == ST_PU) && !io.bus_i[c];
            if (io.conflict_clr_i[c]) begin
               cf_q <= 1'b0;
            end else if (cf_set) begin
               cf_q <= 1'b1;
            end
         end
      end

      assign io.conflict_o[c] = cf_q;
`else
      assign io.conflict_o[c] = 1'b0;
`endif

      a_excl: assert property (@(posedge clk_i)
         !(io.pull_up_en_o[c] && io.pull_down_en_o[c]));

      a_od_no_pu: assert property (@(posedge clk_i) disable iff (rst_i)
         !io.mode_pp_i[c] |=> !io.pull_up_en_o[c]);
   end

`ifndef PP_OD_DRV_CONFLICT_DET_EN
   logic unused_cdet;
   assign unused_cdet = ^{io.bus_i, io.conflict_clr_i};
`endif
endmodule
